alu_op_issuer: RTL

ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

---
 rtl/alu_op_issuer.sv | 103 ++++++++++
 1 files changed

// File: rtl/alu_op_issuer.sv
// ALU operation issuer: accepts one command at a time, drives registered
// operands to the ALU, waits LAT cycles, then captures and holds the result.
//
// Ports:
//   clk, rst (async, active-high)
//   cmd_valid/cmd_ready, cmd_a, cmd_b, cmd_op : command handshake and payload
//   R2, R3, ALUop                             : registered operands/opcode out
//   R0, overflow, zero, carry                 : registered ALU result/flags in
//   rsp_valid/rsp_ready, rsp_result, rsp_*    : captured response handshake
//   busy, op_count                            : status
module alu_op_issuer #(
  parameter int width = 32,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [width-1:0] cmd_a,
  input  logic [width-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [width-1:0] R2,
  output logic [width-1:0] R3,
  output logic [2:0]       ALUop,
  input  logic [width-1:0] R0,
  input  logic             overflow,
  input  logic             zero,
  input  logic             carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [width-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [2:0] LAT3 = 3'(LAT);

  state_t     state;
  logic [2:0] cnt;

  // Handshake signals come from the state register only, so
  // rsp_ready never reaches cmd_ready combinationally.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      R2           <= '0;
      R3           <= '0;
      ALUop        <= 3'd0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      op_count     <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            R2    <= cmd_a;
            R3    <= cmd_b;
            ALUop <= cmd_op;
            cnt   <= LAT3;
            state <= WAIT;
          end
        end
        WAIT: begin
          // cnt==1 marks the edge LAT cycles after accept
          if (cnt == 3'd1) begin
            rsp_result   <= R0;
            rsp_overflow <= overflow;
            rsp_zero     <= zero;
            rsp_carry    <= carry;
            cnt          <= 3'd0;
            state        <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            op_count <= op_count + 16'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
